// File: rtl/rwt_up_regfile_if.sv
// up_* register bus: single-beat write and read request channels with one-cycle acks.
// Latency: none (signal bundle only).
// Backpressure: none on the bus; a responder drops requests it cannot accept.
// Ports: master drives up_wreq/up_waddr/up_wdata and up_rreq/up_raddr;
//        slave drives up_wack, up_rack and up_rdata.
interface rwt_up_regfile_if #(
    parameter int ADDRESS_WIDTH = 14
);
    logic                     up_wreq;
    logic [ADDRESS_WIDTH-1:0] up_waddr;
    logic [31:0]              up_wdata;
    logic                     up_wack;
    logic                     up_rreq;
    logic [ADDRESS_WIDTH-1:0] up_raddr;
    logic [31:0]              up_rdata;
    logic                     up_rack;

    modport master (
        output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        input  up_wack, up_rdata, up_rack
    );

    modport slave (
        input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        output up_wack, up_rdata, up_rack
    );
endinterface

// File: rtl/rwt_up_regfile.sv
// up_* bus responder serving VERSION/SCRATCH/DROP_CNT/STATUS and NUM_CTRL control registers.
// Latency: request sampled at edge N -> ack (and commit/capture) on edge N+1+ACK_DELAY.
// Backpressure: none; a request sampled while its channel is busy is dropped and counted.
// Ports: up_clk/up_rstn plain; up (slave modport) carries both request channels;
//        status_in is readable at 0x3; ctrl_out/ctrl_wstb export the control registers.
module rwt_up_regfile #(
    parameter int          ADDRESS_WIDTH = 14,
    parameter int          NUM_CTRL      = 8,
    parameter int          ACK_DELAY     = 0,
    parameter logic [31:0] VERSION       = 32'h0001_0000
) (
    input  logic                      up_clk,
    input  logic                      up_rstn,
    rwt_up_regfile_if.slave           up,
    input  logic [31:0]               status_in,
    output logic [32*NUM_CTRL-1:0]    ctrl_out,
    output logic [NUM_CTRL-1:0]       ctrl_wstb
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chan_state_e;

    // Reset asserts asynchronously but is released in step with up_clk.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    chan_state_e               wstate_q, rstate_q;
    logic [3:0]                wcnt_q, rcnt_q;
    logic [ADDRESS_WIDTH-1:0]  waddr_q, raddr_q;
    logic [31:0]               wdata_q;
    logic                      wack_q, rack_q;
    logic [31:0]               rdata_q, rdata_d;
    logic [31:0]               scratch_q;
    logic [15:0]               drop_q, drop_d;
    logic [16:0]               drop_sum;
    logic [32*NUM_CTRL-1:0]    ctrl_q;
    logic [NUM_CTRL-1:0]       wstb_q;
    logic                      w_fire, w_drop, r_drop, drop_clr;

    // The ack edge is the last BUSY edge; a request seen on that edge is still dropped.
    assign w_fire   = (wstate_q == BUSY) && (wcnt_q == 4'd0);
    assign w_drop   = up.up_wreq && (wstate_q == BUSY);
    assign r_drop   = up.up_rreq && (rstate_q == BUSY);
    assign drop_clr = w_fire && (waddr_q == ADDRESS_WIDTH'(2));

    // Write channel: commit, strobe and ack all land on the same edge.
    always_ff @(posedge up_clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q  <= IDLE;
            wcnt_q    <= 4'd0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wack_q    <= 1'b0;
            wstb_q    <= '0;
            scratch_q <= '0;
            ctrl_q    <= '0;
        end else begin
            wack_q <= 1'b0;
            wstb_q <= '0;
            case (wstate_q)
                IDLE: begin
                    if (up.up_wreq) begin
                        wstate_q <= BUSY;
                        waddr_q  <= up.up_waddr;
                        wdata_q  <= up.up_wdata;
                        wcnt_q   <= 4'(ACK_DELAY);
                    end
                end
                BUSY: begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        wack_q   <= 1'b1;
                        wstate_q <= IDLE;
                        if (waddr_q == ADDRESS_WIDTH'(1)) begin
                            scratch_q <= wdata_q;
                        end
                        for (int k = 0; k < NUM_CTRL; k++) begin
                            if (waddr_q == ADDRESS_WIDTH'(k + 4)) begin
                                ctrl_q[32*k +: 32] <= wdata_q;
                                wstb_q[k]          <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Read mux sees register state before any same-edge write commit.
    always_comb begin
        rdata_d = '0;
        if (raddr_q == ADDRESS_WIDTH'(0)) begin
            rdata_d = VERSION;
        end else if (raddr_q == ADDRESS_WIDTH'(1)) begin
            rdata_d = ~scratch_q;
        end else if (raddr_q == ADDRESS_WIDTH'(2)) begin
            rdata_d = {16'h0000, drop_q};
        end else if (raddr_q == ADDRESS_WIDTH'(3)) begin
            rdata_d = status_in;
        end
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (raddr_q == ADDRESS_WIDTH'(k + 4)) begin
                rdata_d = ctrl_q[32*k +: 32];
            end
        end
    end

    // Read channel: rdata is captured on the ack edge and held until the next ack.
    always_ff @(posedge up_clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q <= IDLE;
            rcnt_q   <= 4'd0;
            raddr_q  <= '0;
            rack_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rack_q <= 1'b0;
            case (rstate_q)
                IDLE: begin
                    if (up.up_rreq) begin
                        rstate_q <= BUSY;
                        raddr_q  <= up.up_raddr;
                        rcnt_q   <= 4'(ACK_DELAY);
                    end
                end
                BUSY: begin
                    if (rcnt_q != 4'd0) begin
                        rcnt_q <= rcnt_q - 4'd1;
                    end else begin
                        rack_q   <= 1'b1;
                        rdata_q  <= rdata_d;
                        rstate_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Drop counter: both channels may drop on one edge; saturates; clear wins.
    always_comb begin
        drop_sum = {1'b0, drop_q} + 17'(w_drop) + 17'(r_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (drop_clr) begin
            drop_d = '0;
        end
    end

    always_ff @(posedge up_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign up.up_wack  = wack_q;
    assign up.up_rack  = rack_q;
    assign up.up_rdata = rdata_q;
    assign ctrl_out    = ctrl_q;
    assign ctrl_wstb   = wstb_q;
endmodule

// File: tb/tb_rwt_up_regfile.sv
// Bench for rwt_up_regfile: two instances (ACK_DELAY 0 and 3) driven by directed and random traffic.
// Latency: a time-based reference model predicts every ack edge and register value.
// Backpressure: the model decides which requests are dropped from per-channel busy windows.
module tb_rwt_up_regfile;
    localparam int          AW  = 14;
    localparam int          NC  = 8;
    localparam logic [31:0] VER = 32'h0001_0000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, indexed by instance (0: ACK_DELAY=0, 1: ACK_DELAY=3).
    logic          s_wreq  [2];
    logic          s_rreq  [2];
    logic [AW-1:0] s_waddr [2];
    logic [AW-1:0] s_raddr [2];
    logic [31:0]   s_wdata [2];
    logic [31:0]   status;

    logic             o_wack  [2];
    logic             o_rack  [2];
    logic [31:0]      o_rdata [2];
    logic [32*NC-1:0] o_ctrl  [2];
    logic [NC-1:0]    o_wstb  [2];

    rwt_up_regfile_if #(.ADDRESS_WIDTH(AW)) bus0 ();
    rwt_up_regfile_if #(.ADDRESS_WIDTH(AW)) bus3 ();

    assign bus0.up_wreq  = s_wreq[0];
    assign bus0.up_waddr = s_waddr[0];
    assign bus0.up_wdata = s_wdata[0];
    assign bus0.up_rreq  = s_rreq[0];
    assign bus0.up_raddr = s_raddr[0];
    assign bus3.up_wreq  = s_wreq[1];
    assign bus3.up_waddr = s_waddr[1];
    assign bus3.up_wdata = s_wdata[1];
    assign bus3.up_rreq  = s_rreq[1];
    assign bus3.up_raddr = s_raddr[1];

    assign o_wack[0]  = bus0.up_wack;
    assign o_rack[0]  = bus0.up_rack;
    assign o_rdata[0] = bus0.up_rdata;
    assign o_wack[1]  = bus3.up_wack;
    assign o_rack[1]  = bus3.up_rack;
    assign o_rdata[1] = bus3.up_rdata;

    rwt_up_regfile #(.ADDRESS_WIDTH(AW), .NUM_CTRL(NC), .ACK_DELAY(0), .VERSION(VER)) dut0 (
        .up_clk(clk), .up_rstn(rstn), .up(bus0), .status_in(status),
        .ctrl_out(o_ctrl[0]), .ctrl_wstb(o_wstb[0])
    );

    rwt_up_regfile #(.ADDRESS_WIDTH(AW), .NUM_CTRL(NC), .ACK_DELAY(3), .VERSION(VER)) dut3 (
        .up_clk(clk), .up_rstn(rstn), .up(bus3), .status_in(status),
        .ctrl_out(o_ctrl[1]), .ctrl_wstb(o_wstb[1])
    );

    // ---------------- reference model ----------------
    int               cyc = 0;
    int               dly [2] = '{0, 3};
    logic [31:0]      m_scratch [2];
    logic [32*NC-1:0] m_ctrl    [2];
    int               m_drop    [2];
    logic [31:0]      m_rdata   [2];
    logic [NC-1:0]    m_wstb    [2];
    bit               w_pend [2], r_pend [2];
    int               w_at   [2], r_at   [2];
    int               w_a    [2], r_a    [2];
    logic [31:0]      w_v    [2];

    typedef struct {
        int          d;
        logic [31:0] v;
    } exp_t;
    exp_t exp_w[$];
    exp_t exp_r[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] model_read(int d, int a);
        if (a == 0) return VER;
        if (a == 1) return ~m_scratch[d];
        if (a == 2) return 32'(m_drop[d]);
        if (a == 3) return status;
        if (a >= 4 && a < 4 + NC) return m_ctrl[d][32*(a-4) +: 32];
        return 32'h0;
    endfunction

    task automatic model_step(int d);
        bit   wb, rb, clr;
        int   inc;
        exp_t e;
        m_wstb[d] = '0;
        if (!rstn) begin
            m_scratch[d] = '0; m_ctrl[d] = '0; m_drop[d] = 0; m_rdata[d] = '0;
            w_pend[d] = 0; r_pend[d] = 0;
            return;
        end
        wb  = w_pend[d];
        rb  = r_pend[d];
        clr = 0;
        if (r_pend[d] && r_at[d] == cyc) begin
            m_rdata[d] = model_read(d, r_a[d]);
            e.d = d; e.v = m_rdata[d];
            exp_r.push_back(e);
            r_pend[d] = 0;
        end
        if (w_pend[d] && w_at[d] == cyc) begin
            if (w_a[d] == 1) m_scratch[d] = w_v[d];
            if (w_a[d] == 2) clr = 1;
            if (w_a[d] >= 4 && w_a[d] < 4 + NC) begin
                m_ctrl[d][32*(w_a[d]-4) +: 32] = w_v[d];
                m_wstb[d][w_a[d]-4] = 1'b1;
            end
            e.d = d; e.v = 32'h0;
            exp_w.push_back(e);
            w_pend[d] = 0;
        end
        inc = ((s_wreq[d] && wb) ? 1 : 0) + ((s_rreq[d] && rb) ? 1 : 0);
        if (clr) m_drop[d] = 0;
        else     m_drop[d] = (m_drop[d] + inc > 65535) ? 65535 : m_drop[d] + inc;
        if (s_wreq[d] && !wb) begin
            w_pend[d] = 1; w_at[d] = cyc + 1 + dly[d];
            w_a[d] = int'(s_waddr[d]); w_v[d] = s_wdata[d];
        end
        if (s_rreq[d] && !rb) begin
            r_pend[d] = 1; r_at[d] = cyc + 1 + dly[d];
            r_a[d] = int'(s_raddr[d]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(string name, int d, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          n_wack [2] = '{0, 0};
    int          n_rack [2] = '{0, 0};
    int          w_cyc  [2] = '{0, 0};
    logic [31:0] cap_r  [2];
    logic [NC-1:0] cap_wstb [2];

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                for (int d = 0; d < 2; d++) begin
                    bit ew, er;
                    ew = 0;
                    er = 0;
                    foreach (exp_w[i]) if (exp_w[i].d == d) ew = 1;
                    foreach (exp_r[i]) if (exp_r[i].d == d) er = 1;
                    chk("wack", d, 256'(o_wack[d]), 256'(ew));
                    chk("rack", d, 256'(o_rack[d]), 256'(er));
                    chk("rdata", d, 256'(o_rdata[d]), 256'(m_rdata[d]));
                    chk("ctrl_out", d, 256'(o_ctrl[d]), 256'(m_ctrl[d]));
                    chk("ctrl_wstb", d, 256'(o_wstb[d]), 256'(m_wstb[d]));
                    if (o_wack[d]) begin
                        n_wack[d]++;
                        w_cyc[d]    = cyc;
                        cap_wstb[d] = o_wstb[d];
                    end
                    if (o_rack[d]) begin
                        n_rack[d]++;
                        cap_r[d] = o_rdata[d];
                    end
                end
            end
            exp_w.delete();
            exp_r.delete();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(int d, bit w, logic [AW-1:0] wa, logic [31:0] wd, bit r, logic [AW-1:0] ra);
        s_wreq[d] = w; s_waddr[d] = wa; s_wdata[d] = wd;
        s_rreq[d] = r; s_raddr[d] = ra;
        tick(1);
        s_wreq[d] = 1'b0;
        s_rreq[d] = 1'b0;
    endtask

    task automatic wait_ack(int d, bit rd, int n0);
        int k;
        k = 0;
        while (((rd ? n_rack[d] : n_wack[d]) == n0) && k < 20) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= 20) begin
            errors++;
            $display("FAIL ack_timeout dut%0d read=%0d: no ack within 20 cycles", d, rd);
        end
    endtask

    task automatic do_write(int d, logic [AW-1:0] a, logic [31:0] v);
        int n0;
        n0 = n_wack[d];
        drive(d, 1'b1, a, v, 1'b0, 14'h0);
        wait_ack(d, 1'b0, n0);
    endtask

    task automatic do_read(int d, logic [AW-1:0] a, output logic [31:0] v);
        int n0;
        n0 = n_rack[d];
        drive(d, 1'b0, 14'h0, 32'h0, 1'b1, a);
        wait_ack(d, 1'b1, n0);
        v = cap_r[d];
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 19) return 14'h3FFF;
        return AW'(r);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int c0, n0, n1;
        for (int d = 0; d < 2; d++) begin
            s_wreq[d] = 1'b0; s_rreq[d] = 1'b0;
            s_waddr[d] = '0; s_raddr[d] = '0; s_wdata[d] = '0;
        end
        status = 32'h5A5A_0001;
        tick(3);
        rstn = 1'b1;
        tick(4);

        // Reset state and basic reads, ACK_DELAY=0
        chk("reset_ctrl", 0, 256'(o_ctrl[0]), 256'h0);
        chk("reset_rdata", 0, 256'(o_rdata[0]), 256'h0);
        c0 = cyc;
        do_read(0, 14'h0, v);
        chk("version", 0, 256'(v), 256'(VER));
        do_read(0, 14'h4, v);
        chk("ctrl0_reset_read", 0, 256'(v), 256'h0);

        do_write(0, 14'h1, 32'h1234_5678);
        do_read(0, 14'h1, v);
        chk("scratch_inverse", 0, 256'(v), 256'(32'hEDCB_A987));

        do_write(0, 14'h6, 32'hCAFE_F00D);
        chk("ctrl2_wstb", 0, 256'(cap_wstb[0]), 256'(8'h04));
        chk("ctrl2_out", 0, 256'(o_ctrl[0][95:64]), 256'(32'hCAFE_F00D));
        do_write(0, 14'h3FFF, 32'hFFFF_FFFF);
        chk("unmapped_write_no_effect", 0, 256'(o_ctrl[0]), 256'(32'hCAFE_F00D) << 64);
        do_read(0, 14'h3, v);
        chk("status_read", 0, 256'(v), 256'(32'h5A5A_0001));

        // ACK_DELAY=3: latency and drop of a request issued during BUSY
        c0 = cyc;
        n0 = n_wack[1];
        drive(1, 1'b1, 14'h4, 32'h0000_0011, 1'b0, 14'h0);
        tick(1);
        drive(1, 1'b1, 14'h4, 32'h0000_0022, 1'b0, 14'h0);
        wait_ack(1, 1'b0, n0);
        chk("latency_delay3", 1, 256'(w_cyc[1] - c0), 256'd5);
        tick(8);
        chk("single_ack", 1, 256'(n_wack[1] - n0), 256'd1);
        chk("first_write_kept", 1, 256'(o_ctrl[1][31:0]), 256'h11);
        do_read(1, 14'h2, v);
        chk("drop_cnt_one", 1, 256'(v), 256'd1);
        do_write(1, 14'h2, 32'h0000_00FF);
        do_read(1, 14'h2, v);
        chk("drop_cnt_cleared", 1, 256'(v), 256'd0);

        // Same-edge write and read of one address returns the old value
        do_write(0, 14'h5, 32'h0000_0001);
        n0 = n_rack[0];
        n1 = n_wack[0];
        drive(0, 1'b1, 14'h5, 32'hA5A5_A5A5, 1'b1, 14'h5);
        wait_ack(0, 1'b1, n0);
        wait_ack(0, 1'b0, n1);
        chk("rd_wr_collision_old", 0, 256'(cap_r[0]), 256'h1);
        do_read(0, 14'h5, v);
        chk("rd_after_collision", 0, 256'(v), 256'(32'hA5A5_A5A5));

        // Reset in the middle of a delayed write aborts it
        n0 = n_wack[1];
        drive(1, 1'b1, 14'h4, 32'h0000_BEEF, 1'b0, 14'h0);
        tick(1);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(6);
        chk("no_wack_after_abort", 1, 256'(n_wack[1] - n0), 256'd0);
        chk("ctrl_zero_after_abort", 1, 256'(o_ctrl[1]), 256'h0);
        do_write(1, 14'h4, 32'h0000_0077);
        chk("write_after_abort", 1, 256'(o_ctrl[1][31:0]), 256'h77);

        // Random traffic on both instances against the model
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                s_wreq[d]  = ($urandom_range(0, 99) < 35);
                s_rreq[d]  = ($urandom_range(0, 99) < 35);
                s_waddr[d] = rand_addr();
                s_raddr[d] = rand_addr();
                s_wdata[d] = $urandom();
            end
            if ($urandom_range(0, 9) == 0) status = $urandom();
            tick(1);
        end
        for (int d = 0; d < 2; d++) begin
            s_wreq[d] = 1'b0;
            s_rreq[d] = 1'b0;
        end
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
